// File: rtl/digital_lock_n.sv
// Parametrised N-key digital lock: synchronised and debounced keypad, code entry
// with timeout, reprogrammable code, retry counting with lockout. Single clock domain.
module digital_lock_n #(
    parameter int NUM_KEYS      = 4,
    parameter int CODE_LEN      = 4,
    parameter logic [CODE_LEN*$clog2(NUM_KEYS)-1:0] DEFAULT_CODE = 8'b00_01_10_11,
    parameter int CLK_DIV       = 262144,
    parameter int DEB_TICKS     = 3,
    parameter int TIMEOUT_TICKS = 950,
    parameter int OPEN_TICKS    = 570,
    parameter int FAIL_TICKS    = 190,
    parameter int MAX_TRIES     = 3,
    parameter int LOCKOUT_TICKS = 5700
) (
    input  logic                            mClk,
    input  logic                            Reset,
    input  logic [NUM_KEYS-1:0]             keys,
    input  logic                            prog,
    output logic                            correct,
    output logic                            incorrect,
    output logic                            locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt
);

    localparam int KW    = $clog2(NUM_KEYS);
    localparam int CW    = CODE_LEN * KW;
    localparam int DCW   = $clog2(CODE_LEN + 1);
    localparam int DIVW  = $clog2(CLK_DIV);
    localparam int DEBW  = $clog2(DEB_TICKS + 1);
    localparam int FW    = $clog2(MAX_TRIES + 1);
    localparam int T_AB  = (TIMEOUT_TICKS > OPEN_TICKS) ? TIMEOUT_TICKS : OPEN_TICKS;
    localparam int T_CD  = (FAIL_TICKS > LOCKOUT_TICKS) ? FAIL_TICKS : LOCKOUT_TICKS;
    localparam int T_MAX = (T_AB > T_CD) ? T_AB : T_CD;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_PROGRAM = 3'd4;
    localparam logic [2:0] S_FAIL    = 3'd5;
    localparam logic [2:0] S_LOCKOUT = 3'd6;

    logic [NUM_KEYS-1:0] r_sync1, r_sync2, r_deb, r_deb_prev;
    logic [DEBW-1:0]     r_deb_cnt [NUM_KEYS];
    logic [DIVW-1:0]     r_div;
    logic [2:0]          r_state, w_state_nx;
    logic [CW-1:0]       r_entry, w_entry_nx, r_code, w_code_nx, w_entry_shift;
    logic [DCW-1:0]      r_digit_cnt, w_cnt_nx;
    logic [FW-1:0]       r_fail_cnt, w_fail_nx;
    logic [TW-1:0]       r_timer;
    logic                r_correct, r_incorrect, r_locked_out;
    logic                w_tick, w_onehot, w_event, w_timeout, w_timer_clr;
    logic [KW-1:0]       w_digit;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge mClk or negedge Reset) begin
        if (!Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_div   <= '0;
        end else begin
            r_sync1 <= keys;
            r_sync2 <= r_sync1;
            r_div   <= (r_div == DIVW'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
        end
    end

    assign w_tick = (r_div == DIVW'(CLK_DIV - 1));

    // A key level flips only after DEB_TICKS consecutive tick samples disagree with it.
    always_ff @(posedge mClk or negedge Reset) begin
        if (!Reset) begin
            r_deb      <= '0;
            r_deb_prev <= '0;
            for (int k = 0; k < NUM_KEYS; k++) r_deb_cnt[k] <= '0;
        end else begin
            r_deb_prev <= r_deb;
            if (w_tick) begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (r_sync2[k] == r_deb[k]) begin
                        r_deb_cnt[k] <= '0;
                    end else if (r_deb_cnt[k] == DEBW'(DEB_TICKS - 1)) begin
                        r_deb[k]     <= ~r_deb[k];
                        r_deb_cnt[k] <= '0;
                    end else begin
                        r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    assign w_onehot = (r_deb != '0) && ((r_deb & (r_deb - 1'b1)) == '0);
    assign w_event  = (r_deb_prev == '0) && w_onehot;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_digit = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (r_deb[k]) w_digit = KW'(k);
        end
    end

    if (CODE_LEN == 1) begin : g_one_digit
        assign w_entry_shift = w_digit;
    end else begin : g_multi_digit
        assign w_entry_shift = {r_entry[CW-KW-1:0], w_digit};
    end

    assign w_timeout = w_tick && (r_timer == TW'(TIMEOUT_TICKS - 1));

    always_comb begin
        w_state_nx  = r_state;
        w_entry_nx  = r_entry;
        w_code_nx   = r_code;
        w_cnt_nx    = r_digit_cnt;
        w_fail_nx   = r_fail_cnt;
        w_timer_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_event) begin
                    w_entry_nx = w_entry_shift;
                    w_cnt_nx   = DCW'(1);
                    w_state_nx = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (w_event) begin
                    w_entry_nx  = w_entry_shift;
                    w_cnt_nx    = r_digit_cnt + 1'b1;
                    w_timer_clr = 1'b1;
                    if (r_digit_cnt == DCW'(CODE_LEN - 1)) w_state_nx = S_CHECK;
                end else if (w_timeout) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end
            end
            S_CHECK: begin
                w_cnt_nx = '0;
                if (r_entry == r_code) begin
                    w_fail_nx  = '0;
                    w_state_nx = S_OPEN;
                end else if (r_fail_cnt >= FW'(MAX_TRIES - 1)) begin
                    w_fail_nx  = FW'(MAX_TRIES);
                    w_state_nx = S_LOCKOUT;
                end else begin
                    w_fail_nx  = r_fail_cnt + 1'b1;
                    w_state_nx = S_FAIL;
                end
            end
            S_OPEN: begin
                if (prog) begin
                    w_state_nx = S_PROGRAM;
                end else if (w_tick && r_timer == TW'(OPEN_TICKS - 1)) begin
                    w_state_nx = S_IDLE;
                end
            end
            S_PROGRAM: begin
                // The full new code is committed one cycle after its last digit.
                if (r_digit_cnt == DCW'(CODE_LEN)) begin
                    w_code_nx  = r_entry;
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end else if (w_event) begin
                    w_entry_nx  = w_entry_shift;
                    w_cnt_nx    = r_digit_cnt + 1'b1;
                    w_timer_clr = 1'b1;
                end else if (w_timeout) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end
            end
            S_FAIL: begin
                if (w_tick && r_timer == TW'(FAIL_TICKS - 1)) w_state_nx = S_IDLE;
            end
            S_LOCKOUT: begin
                if (w_tick && r_timer == TW'(LOCKOUT_TICKS - 1)) begin
                    w_fail_nx  = '0;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge mClk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_entry      <= '0;
            r_code       <= DEFAULT_CODE;
            r_digit_cnt  <= '0;
            r_fail_cnt   <= '0;
            r_timer      <= '0;
            r_correct    <= 1'b0;
            r_incorrect  <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_entry      <= w_entry_nx;
            r_code       <= w_code_nx;
            r_digit_cnt  <= w_cnt_nx;
            r_fail_cnt   <= w_fail_nx;
            if (w_state_nx != r_state || w_timer_clr) r_timer <= '0;
            else if (w_tick)                          r_timer <= r_timer + 1'b1;
            r_correct    <= (w_state_nx == S_OPEN) || (w_state_nx == S_PROGRAM);
            r_incorrect  <= (w_state_nx == S_FAIL) || (w_state_nx == S_LOCKOUT);
            r_locked_out <= (w_state_nx == S_LOCKOUT);
        end
    end

    assign correct    = r_correct;
    assign incorrect  = r_incorrect;
    assign locked_out = r_locked_out;
    assign digit_cnt  = r_digit_cnt;

endmodule

// File: tb/tb_digital_lock_n.sv
// Self-checking bench for digital_lock_n: table of code entries with expected
// outcome and duration, plus hand sequences for glitches, timeout, programming and reset.
module tb_digital_lock_n;

    localparam int CLK_DIV = 4;

    typedef struct {
        logic [7:0] code;
        logic       exp_c;
        logic       exp_i;
        logic       exp_l;
        int         ticks;
        bit         poke;
    } vec_t;

    logic       mClk = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] keys = 4'b0000;
    logic       prog = 1'b0;
    logic       correct, incorrect, locked_out;
    logic [2:0] digit_cnt;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tbl [13];

    digital_lock_n #(
        .NUM_KEYS(4), .CODE_LEN(4), .DEFAULT_CODE(8'b00_01_10_11),
        .CLK_DIV(CLK_DIV), .DEB_TICKS(2), .TIMEOUT_TICKS(20), .OPEN_TICKS(10),
        .FAIL_TICKS(5), .MAX_TRIES(3), .LOCKOUT_TICKS(30)
    ) dut (
        .mClk(mClk), .Reset(Reset), .keys(keys), .prog(prog),
        .correct(correct), .incorrect(incorrect), .locked_out(locked_out),
        .digit_cnt(digit_cnt)
    );

    always #5 mClk = ~mClk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge mClk);
    endtask

    task automatic press(input int k);
        keys = 4'(1 << k);
        wait_cyc(24);
        keys = 4'b0000;
        wait_cyc(24);
    endtask

    // Press all but the last digit, hold the last one until an outcome appears.
    task automatic lead_in(input logic [7:0] code, input string name, output bit found);
        logic [1:0] d;
        for (int j = 0; j < 3; j++) begin
            d = code[7-2*j -: 2];
            press(int'(d));
        end
        check({name, " cnt3"}, 32'(digit_cnt), 3);
        d = code[1:0];
        keys = 4'(1 << d);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge mClk);
            if (correct || incorrect) begin
                found = 1'b1;
                break;
            end
        end
        check({name, " start"}, 32'(found), 1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        bit found;
        int dur, nz;
        lead_in(v.code, name, found);
        if (found) begin
            keys = 4'b0000;
            check({name, " correct"},    32'(correct),    32'(v.exp_c));
            check({name, " incorrect"},  32'(incorrect),  32'(v.exp_i));
            check({name, " locked_out"}, 32'(locked_out), 32'(v.exp_l));
            dur = 0;
            nz  = 0;
            while ((correct || incorrect) && dur < v.ticks * CLK_DIV + 20) begin
                if (v.poke && dur == 4)  keys = 4'b0100;
                if (v.poke && dur == 16) keys = 4'b0000;
                if (digit_cnt !== 3'd0) nz++;
                dur++;
                @(negedge mClk);
            end
            check_range({name, " duration"}, dur, (v.ticks - 1) * CLK_DIV + 1, v.ticks * CLK_DIV);
            check({name, " keys ignored"}, 32'(nz), 0);
        end
        keys = 4'b0000;
        wait_cyc(40);
        check({name, " idle outputs"}, 32'({correct, incorrect, locked_out}), 0);
        check({name, " idle cnt"}, 32'(digit_cnt), 0);
    endtask

    task automatic open_then_prog(input logic [7:0] code, input string name);
        bit found;
        lead_in(code, name, found);
        check({name, " opened"}, 32'(correct), 1);
        prog = 1'b1;
        wait_cyc(2);
        prog = 1'b0;
        keys = 4'b0000;
        wait_cyc(24);
        check({name, " prog cnt0"}, 32'(digit_cnt), 0);
    endtask

    initial begin
        int inc_seen;
        vec_t v;

        tbl[0]  = '{8'h1B, 1'b1, 1'b0, 1'b0, 10, 1'b1};  // 0123 opens, presses ignored
        tbl[1]  = '{8'h1A, 1'b0, 1'b1, 1'b0,  5, 1'b1};  // 0122 fail 1
        tbl[2]  = '{8'h1A, 1'b0, 1'b1, 1'b0,  5, 1'b0};  // fail 2
        tbl[3]  = '{8'h1A, 1'b0, 1'b1, 1'b1, 30, 1'b1};  // fail 3 -> lockout
        tbl[4]  = '{8'h1B, 1'b1, 1'b0, 1'b0, 10, 1'b0};
        tbl[5]  = '{8'hE4, 1'b0, 1'b1, 1'b0,  5, 1'b0};  // 3210
        tbl[6]  = '{8'h1B, 1'b1, 1'b0, 1'b0, 10, 1'b0};
        tbl[7]  = '{8'h55, 1'b0, 1'b1, 1'b0,  5, 1'b0};  // 1111
        tbl[8]  = '{8'hAA, 1'b0, 1'b1, 1'b0,  5, 1'b0};  // 2222
        tbl[9]  = '{8'h1B, 1'b1, 1'b0, 1'b0, 10, 1'b0};  // clears the two failures
        tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b0,  5, 1'b0};
        tbl[11] = '{8'h00, 1'b0, 1'b1, 1'b0,  5, 1'b0};  // only second failure since clear
        tbl[12] = '{8'h1B, 1'b1, 1'b0, 1'b0, 10, 1'b0};

        #1;
        check("reset outputs", 32'({correct, incorrect, locked_out}), 0);
        check("reset cnt", 32'(digit_cnt), 0);
        wait_cyc(3);
        Reset = 1'b1;
        wait_cyc(8);

        for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // One-tick glitch and a two-key chord must not produce events.
        keys = 4'b0010;
        wait_cyc(4);
        keys = 4'b0000;
        wait_cyc(24);
        check("glitch cnt", 32'(digit_cnt), 0);
        keys = 4'b0101;
        wait_cyc(24);
        check("chord held cnt", 32'(digit_cnt), 0);
        keys = 4'b0000;
        wait_cyc(24);
        check("chord released cnt", 32'(digit_cnt), 0);

        // Two failures, then an abandoned entry, then the right code still opens.
        v = '{8'h1A, 1'b0, 1'b1, 1'b0, 5, 1'b0};
        run_vec(v, "pre-timeout fail a");
        run_vec(v, "pre-timeout fail b");
        press(0);
        check("partial cnt1", 32'(digit_cnt), 1);
        press(1);
        check("partial cnt2", 32'(digit_cnt), 2);
        inc_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 30) check("before timeout cnt", 32'(digit_cnt), 2);
            if (i == 50) check("after timeout cnt", 32'(digit_cnt), 0);
            if (incorrect || correct) inc_seen++;
            @(negedge mClk);
        end
        check("timeout no outcome", 32'(inc_seen), 0);
        run_vec('{8'h1B, 1'b1, 1'b0, 1'b0, 10, 1'b0}, "after timeout");

        // Reprogram to 3,3,0,1.
        open_then_prog(8'h1B, "prog");
        press(3);
        press(3);
        press(0);
        check("prog cnt3", 32'(digit_cnt), 3);
        press(1);
        check("prog commit outputs", 32'({correct, incorrect, locked_out}), 0);
        check("prog commit cnt", 32'(digit_cnt), 0);
        run_vec('{8'h1B, 1'b0, 1'b1, 1'b0,  5, 1'b0}, "old code");
        run_vec('{8'hF1, 1'b1, 1'b0, 1'b0, 10, 1'b0}, "new code");

        // Reset in the middle of programming restores the default code.
        open_then_prog(8'hF1, "rst prog");
        press(2);
        press(2);
        check("rst prog cnt2", 32'(digit_cnt), 2);
        #2;
        Reset = 1'b0;
        #1;
        check("async reset outputs", 32'({correct, incorrect, locked_out}), 0);
        check("async reset cnt", 32'(digit_cnt), 0);
        wait_cyc(3);
        Reset = 1'b1;
        wait_cyc(8);
        run_vec('{8'h1B, 1'b1, 1'b0, 1'b0, 10, 1'b0}, "default after reset");
        run_vec('{8'hF1, 1'b0, 1'b1, 1'b0,  5, 1'b0}, "programmed lost");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
